// File: rtl/jk_excitation_counter_if.sv
// Control and observation bundle for jk_excitation_counter.
// Master drives count controls; slave (the counter) returns state and excitation.
interface jk_excitation_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             tc;
  logic             err;

  modport master (
    output en, up, load, din,
    input  q, qbar, j, k, tc, err
  );

  modport slave (
    input  en, up, load, din,
    output q, qbar, j, k, tc, err
  );
endinterface

// File: rtl/jk_excitation_counter.sv
// Mod-MODULUS up/down counter built from a bank of JK state bits fed by excitation logic.
// Define SYNC_CNT_SATURATE_EN to hold at the boundaries instead of wrapping.
module jk_excitation_bit (
  input  logic clk,
  input  logic rst,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= 1'b0;
    else     o_q <= (i_j & ~o_q) | (~i_k & o_q);
  end
endmodule

module jk_excitation_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_excitation_counter_if.slave bus
);
  localparam logic [WIDTH:0]   MOD  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_n;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_din_bad;
  logic             w_tc;
  logic             r_err;

  assign w_at_max  = (w_q == MAXV);
  assign w_at_zero = (w_q == '0);
  assign w_din_bad = ({1'b0, bus.din} >= MOD);

  always_comb begin
    w_n = w_q;
    if (bus.load) begin
      w_n = w_din_bad ? MAXV : bus.din;
    end else if (bus.en && bus.up) begin
`ifdef SYNC_CNT_SATURATE_EN
      w_n = w_at_max ? MAXV : w_q + 1'b1;
`else
      w_n = w_at_max ? '0 : w_q + 1'b1;
`endif
    end else if (bus.en) begin
`ifdef SYNC_CNT_SATURATE_EN
      w_n = w_at_zero ? '0 : w_q - 1'b1;
`else
      w_n = w_at_zero ? MAXV : w_q - 1'b1;
`endif
    end
  end

  // Excitation table with don't-cares at 0: only real transitions drive J or K.
  assign w_j  = rst ? '0 : (~w_q &  w_n);
  assign w_k  = rst ? '0 : ( w_q & ~w_n);
  assign w_tc = ~rst & bus.en & ~bus.load &
                ((bus.up & w_at_max) | (~bus.up & w_at_zero));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_excitation_bit u_bit (
        .clk (clk),
        .rst (rst),
        .i_j (w_j[gi]),
        .i_k (w_k[gi]),
        .o_q (w_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_err <= 1'b0;
    else if (bus.load && w_din_bad)   r_err <= 1'b1;
  end

  assign bus.q    = w_q;
  assign bus.qbar = ~w_q;
  assign bus.j    = w_j;
  assign bus.k    = w_k;
  assign bus.tc   = w_tc;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_jk_excitation_counter.sv
// Randomized and directed checks of jk_excitation_counter against an arithmetic model.
module tb_jk_excitation_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   mq;
  bit   merr;

  jk_excitation_counter_if #(.WIDTH(W)) bus();
  jk_excitation_counter #(.WIDTH(W), .MODULUS(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: next count from the counting rules in plain integer arithmetic.
  function automatic int mnext(int q, bit ld, int d, bit e, bit u);
    if (ld) return (d < M) ? d : M - 1;
`ifdef SYNC_CNT_SATURATE_EN
    if (e && u)  return (q + 1 > M - 1) ? M - 1 : q + 1;
    if (e && !u) return (q - 1 < 0) ? 0 : q - 1;
`else
    if (e && u)  return (q + 1) % M;
    if (e && !u) return (q + M - 1) % M;
`endif
    return q;
  endfunction

  function automatic bit mtc(int q, bit ld, bit e, bit u);
    return e && !ld && ((u && q == M - 1) || (!u && q == 0));
  endfunction

  task automatic drive(bit e, bit u, bit ld, int d);
    bus.en = e; bus.up = u; bus.load = ld; bus.din = W'(d);
    #1;
  endtask

  task automatic edge_step();
    int n;
    n = mnext(mq, bus.load, int'(bus.din), bus.en, bus.up);
    if (bus.load && int'(bus.din) >= M) merr = 1'b1;
    @(posedge clk); #1;
    mq = n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    mq = 0; merr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0);
    repeat (7) edge_step();
    n_tests++;
    if (bus.q !== 4'd7) begin n_fail++; $display("FAIL reset_pre q=%0d exp=7", bus.q); end
    #2;
    rst = 1'b1;
    #1;
    mq = 0; merr = 1'b0;
    n_tests++;
    if (bus.q !== 4'd0 || bus.qbar !== 4'hF) begin
      n_fail++; $display("FAIL reset_async q=%h qbar=%h exp q=0 qbar=f", bus.q, bus.qbar);
    end
    n_tests++;
    if (bus.j !== 4'd0 || bus.k !== 4'd0 || bus.tc !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs j=%b k=%b tc=%b err=%b exp all 0", bus.j, bus.k, bus.tc, bus.err);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    n_tests++;
    if (bus.q !== W'(mq)) begin n_fail++; $display("FAIL reset_resume q=%0d exp=%0d", bus.q, mq); end
  endtask

  task automatic test_up_wrap();
    int seq [12] = '{1,2,3,4,5,6,7,8,9,0,1,2};
    do_reset();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (bus.tc !== mtc(mq, 0, 1, 1) || (bus.j & bus.k) !== 4'd0) begin
        n_fail++; $display("FAIL up_tc q=%0d tc=%b j=%b k=%b", mq, bus.tc, bus.j, bus.k);
      end
`ifndef SYNC_CNT_SATURATE_EN
      if (mq == 9) begin
        n_tests++;
        if (bus.tc !== 1'b1 || bus.j !== 4'b0000 || bus.k !== 4'b1001) begin
          n_fail++; $display("FAIL up_at9 tc=%b j=%b k=%b exp 1 0000 1001", bus.tc, bus.j, bus.k);
        end
      end
`endif
      edge_step();
      n_tests++;
`ifndef SYNC_CNT_SATURATE_EN
      if (bus.q !== W'(seq[i])) begin n_fail++; $display("FAIL up_seq[%0d] q=%0d exp=%0d", i, bus.q, seq[i]); end
`else
      if (bus.q !== W'(mq)) begin n_fail++; $display("FAIL up_seq[%0d] q=%0d exp=%0d", i, bus.q, mq); end
`endif
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    drive(1, 0, 0, 0);
    n_tests++;
`ifndef SYNC_CNT_SATURATE_EN
    if (bus.tc !== 1'b1 || bus.j !== 4'b1001 || bus.k !== 4'b0000) begin
      n_fail++; $display("FAIL down_at0 tc=%b j=%b k=%b exp 1 1001 0000", bus.tc, bus.j, bus.k);
    end
`else
    if (bus.tc !== 1'b1 || bus.j !== 4'b0000 || bus.k !== 4'b0000) begin
      n_fail++; $display("FAIL down_at0 tc=%b j=%b k=%b exp 1 0000 0000", bus.tc, bus.j, bus.k);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      edge_step();
      n_tests++;
      if (bus.q !== W'(mq)) begin n_fail++; $display("FAIL down_seq[%0d] q=%0d exp=%0d", i, bus.q, mq); end
    end
`ifndef SYNC_CNT_SATURATE_EN
    n_tests++;
    if (bus.q !== 4'd7) begin n_fail++; $display("FAIL down_end q=%0d exp=7", bus.q); end
`endif
  endtask

  task automatic test_load_clamp();
    do_reset();
    drive(1, 1, 0, 0);
    repeat (9) edge_step();
    drive(1, 1, 1, 5);
    n_tests++;
    if (bus.tc !== 1'b0) begin n_fail++; $display("FAIL load_tc tc=%b exp=0", bus.tc); end
    edge_step();
    n_tests++;
    if (bus.q !== 4'd5 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL load5 q=%0d err=%b exp 5 0", bus.q, bus.err);
    end
    drive(0, 0, 1, 12);
    edge_step();
    n_tests++;
    if (bus.q !== 4'd9 || bus.err !== 1'b1) begin
      n_fail++; $display("FAIL load12 q=%0d err=%b exp 9 1", bus.q, bus.err);
    end
    drive(1, 1, 0, 0);
    repeat (5) edge_step();
    n_tests++;
    if (bus.err !== 1'b1 || bus.q !== W'(mq)) begin
      n_fail++; $display("FAIL err_sticky err=%b q=%0d exp 1 %0d", bus.err, bus.q, mq);
    end
  endtask

  task automatic test_hold();
    drive(0, 0, 1, 6);
    edge_step();
    drive(0, $urandom_range(0, 1), 0, $urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.j !== 4'd0 || bus.k !== 4'd0 || bus.tc !== 1'b0) begin
        n_fail++; $display("FAIL hold_exc j=%b k=%b tc=%b exp 0", bus.j, bus.k, bus.tc);
      end
      edge_step();
      n_tests++;
      if (bus.q !== 4'd6) begin n_fail++; $display("FAIL hold_q q=%0d exp=6", bus.q); end
    end
  endtask

`ifdef SYNC_CNT_SATURATE_EN
  task automatic test_saturate();
    int dn [2] = '{0, 0};
    drive(0, 0, 1, 8);
    edge_step();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      n_tests++;
      if (bus.q !== 4'd9 || bus.tc !== 1'b1 || bus.j !== 4'd0 || bus.k !== 4'd0) begin
        n_fail++; $display("FAIL sat_up q=%0d tc=%b j=%b k=%b exp 9 1 0 0", bus.q, bus.tc, bus.j, bus.k);
      end
    end
    drive(0, 0, 1, 1);
    edge_step();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      edge_step();
      n_tests++;
      if (bus.q !== W'(dn[i])) begin n_fail++; $display("FAIL sat_dn q=%0d exp=%0d", bus.q, dn[i]); end
    end
  endtask
`endif

  task automatic test_random();
    bit e, u, ld;
    int d, n;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 9) < 8);
      u  = $urandom_range(0, 1);
      ld = ($urandom_range(0, 9) < 2);
      d  = $urandom_range(0, 15);
      drive(e, u, ld, d);
      n = mnext(mq, ld, d, e, u);
      n_tests++;
      if (bus.j !== W'(~mq & n) || bus.k !== W'(mq & ~n) || bus.tc !== mtc(mq, ld, e, u)) begin
        n_fail++;
        $display("FAIL rand_exc[%0d] q=%0d j=%b k=%b tc=%b exp j=%b k=%b tc=%b",
                 i, mq, bus.j, bus.k, bus.tc, W'(~mq & n), W'(mq & ~n), mtc(mq, ld, e, u));
      end
      edge_step();
      n_tests++;
      if (bus.q !== W'(mq) || bus.qbar !== ~W'(mq) || bus.err !== merr) begin
        n_fail++; $display("FAIL rand_state[%0d] q=%0d qbar=%h err=%b exp q=%0d err=%b",
                           i, bus.q, bus.qbar, bus.err, mq, merr);
      end
      if (i % 97 == 96) do_reset();
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mq = 0; merr = 1'b0;
    rst = 1'b1;
    bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.din = '0;
    #2;
    n_tests++;
    if (bus.q !== 4'd0 || bus.qbar !== 4'hF || bus.err !== 1'b0 || bus.tc !== 1'b0) begin
      n_fail++; $display("FAIL por q=%h qbar=%h err=%b tc=%b", bus.q, bus.qbar, bus.err, bus.tc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_hold();
`ifdef SYNC_CNT_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
